// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a shared byte-write word memory
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             grant_i;
  logic             grant_d;

  logic [1:0]  d_off;
  logic [1:0]  d_size;      // 0 byte, 1 half, 2 word
  logic        d_legal;
  logic        d_misal;
  logic        d_bad;
  logic [3:0]  d_lanes;
  logic [31:0] d_wrep;
  logic [31:0] load_shift;
  logic [31:0] load_ext;
  logic        i_misal;

  assign d_off   = d_addr[1:0];
  assign i_misal = |i_addr[1:0];

  // Pick at most one requester; D wins unless I has waited STARVE_LIMIT D grants
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (RESET_N) begin
      if (d_valid && (!i_valid || starve_cnt != LIMIT)) begin
        grant_d = 1'b1;
      end else if (i_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  // Decode access size, legality, alignment, byte lanes and replicated store data
  always_comb begin
    d_size  = 2'd2;
    d_legal = 1'b0;
    case (d_funct3)
      3'b000: begin d_size = 2'd0; d_legal = 1'b1;  end
      3'b001: begin d_size = 2'd1; d_legal = 1'b1;  end
      3'b010: begin d_size = 2'd2; d_legal = 1'b1;  end
      3'b100: begin d_size = 2'd0; d_legal = !d_we; end
      3'b101: begin d_size = 2'd1; d_legal = !d_we; end
      default: begin d_size = 2'd2; d_legal = 1'b0; end
    endcase

    case (d_size)
      2'd1:    d_misal = d_off[0];
      2'd2:    d_misal = (d_off != 2'd0);
      default: d_misal = 1'b0;
    endcase
    d_bad = !d_legal || d_misal;

    case (d_size)
      2'd0: begin
        d_lanes = 4'b0001 << d_off;
        d_wrep  = {4{d_wdata[7:0]}};
      end
      2'd1: begin
        d_lanes = 4'b0011 << d_off;
        d_wrep  = {2{d_wdata[15:0]}};
      end
      default: begin
        d_lanes = 4'b1111;
        d_wrep  = d_wdata;
      end
    endcase
  end

  // Align the addressed byte/half to bit 0 and sign- or zero-extend it
  always_comb begin
    load_shift = mem_rdata >> {d_off, 3'b000};
    case (d_size)
      2'd0: load_ext = d_funct3[2] ? {24'b0, load_shift[7:0]}
                                   : {{24{load_shift[7]}}, load_shift[7:0]};
      2'd1: load_ext = d_funct3[2] ? {16'b0, load_shift[15:0]}
                                   : {{16{load_shift[15]}}, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Memory-side drive: address of the winner, writes only for clean stores
  always_comb begin
    i_ready   = grant_i;
    d_ready   = grant_d;
    mem_addr  = grant_d ? d_addr : i_addr;
    mem_wdata = d_wrep;
    mem_we    = (grant_d && d_we && !d_bad) ? d_lanes : 4'b0000;
  end

  // Count consecutive D grants that left a pending fetch waiting
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt <= '0;
    end else if (!i_valid || grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Fetch response: one-cycle pulse after the grant, zero data on misalignment
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
    end else begin
      i_rvalid <= grant_i;
      if (grant_i) begin
        i_err   <= i_misal;
        i_rdata <= i_misal ? 32'b0 : mem_rdata;
      end
    end
  end

  // Load/store response: extended load data, zero for stores and faulting accesses
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= grant_d;
      if (grant_d) begin
        d_err   <= d_bad;
        d_rdata <= (d_bad || d_we) ? 32'b0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_valid = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'b010;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_we(d_we), .d_funct3(d_funct3),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory array the arbiter drives
  logic [31:0] env_mem [0:1023];
  assign mem_rdata = env_mem[mem_addr[11:2]];
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) env_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model state
  logic [31:0] shadow [0:1023];
  int          streak = 0;
  bit          exp_i_pend = 0, exp_d_pend = 0;
  logic [31:0] exp_i_rdata = '0, exp_d_rdata = '0;
  bit          exp_i_err = 0, exp_d_err = 0;
  bit          i_taken = 0, d_taken = 0;
  int          n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit access_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!we && (f3 == 3'd4 || f3 == 3'd5));
    if (!legal) return 1'b1;
    return (int'(addr[1:0]) % nbytes_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int    n, off;
    longint v, span;
    n    = nbytes_of(f3);
    off  = int'(addr[1:0]);
    span = longint'(1) << (8 * n);
    v    = (longint'(word) >> (8 * off)) % span;
    if (!f3[2] && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] wd, input int n);
    longint v, unit;
    unit = longint'(wd) % (longint'(1) << (8 * n));
    v = 0;
    for (int k = 0; k < 4 / n; k++) v = v + (unit << (8 * n * k));
    return v[31:0];
  endfunction

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge CLK) begin
    bit gi, gd, bad;
    int n, off, idx;
    if (!RESET_N) begin
      chk("rst i_ready", 32'(i_ready), 32'd0);
      chk("rst d_ready", 32'(d_ready), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst i_rvalid", 32'(i_rvalid), 32'd0);
      chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
      exp_i_pend = 0; exp_d_pend = 0; streak = 0; i_taken = 0; d_taken = 0;
    end else begin
      chk("i_rvalid", 32'(i_rvalid), 32'(exp_i_pend));
      if (exp_i_pend) begin
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("i_err", 32'(i_err), 32'(exp_i_err));
      end
      chk("d_rvalid", 32'(d_rvalid), 32'(exp_d_pend));
      if (exp_d_pend) begin
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("d_err", 32'(d_err), 32'(exp_d_err));
      end

      gd = d_valid && (!i_valid || streak < LIM);
      gi = i_valid && !gd;
      chk("i_ready", 32'(i_ready), 32'(gi));
      chk("d_ready", 32'(d_ready), 32'(gd));
      chk("mem_addr", mem_addr, gd ? d_addr : i_addr);

      if (gd) begin
        bad = access_bad(d_we, d_funct3, d_addr);
        n   = nbytes_of(d_funct3);
        off = int'(d_addr[1:0]);
        idx = int'(d_addr[11:2]);
        exp_d_err   = bad;
        exp_d_rdata = (bad || d_we) ? 32'd0 : load_value(shadow[idx], d_funct3, d_addr);
        if (d_we && !bad) begin
          chk("mem_we", 32'(mem_we), 32'(((1 << n) - 1) << off));
          chk("mem_wdata", mem_wdata, replicate(d_wdata, n));
          for (int b = 0; b < n; b++) shadow[idx][8*(off+b) +: 8] = d_wdata[8*b +: 8];
        end else begin
          chk("mem_we", 32'(mem_we), 32'd0);
        end
      end else begin
        chk("mem_we idle", 32'(mem_we), 32'd0);
      end

      if (gi) begin
        exp_i_err   = (i_addr[1:0] != 2'd0);
        exp_i_rdata = exp_i_err ? 32'd0 : shadow[int'(i_addr[11:2])];
      end

      exp_i_pend = gi;
      exp_d_pend = gd;
      if (!i_valid || gi) streak = 0;
      else if (gd && streak < LIM) streak++;
      i_taken = gi;
      d_taken = gd;
    end
  end

  // One directed D access presented at posedge+1, with literal expectations
  task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] exp_we,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input string nm);
    d_valid = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd; i_valid = 1'b0;
    @(negedge CLK); #1;
    chk({nm, " ready"}, 32'(d_ready), 32'd1);
    chk({nm, " we"}, 32'(mem_we), 32'(exp_we));
    if (exp_we != 4'd0) chk({nm, " wdata"}, mem_wdata, exp_wdata);
    @(posedge CLK); #1;
    d_valid = 1'b0;
    chk({nm, " rvalid"}, 32'(d_rvalid), 32'd1);
    chk({nm, " rdata"}, d_rdata, exp_rd);
    chk({nm, " err"}, 32'(d_err), 32'(exp_err));
  endtask

  // Hold both requesters for n cycles and record which one won each cycle
  task automatic run_both(input int n, input logic [7:0] i_off_mask, output logic [15:0] seq);
    seq = '0;
    d_valid = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h100;
    i_addr = 32'h200;
    for (int k = 0; k < n; k++) begin
      i_valid = !(k < 8 && i_off_mask[k]);
      @(negedge CLK); #1;
      seq[k] = d_ready;
      @(posedge CLK); #1;
    end
    d_valid = 1'b0; i_valid = 1'b0;
  endtask

  logic [15:0] seq;
  logic [31:0] r;
  logic [2:0]  f3_tab [0:9];

  initial begin
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
    f3_tab[5] = 3'd2; f3_tab[6] = 3'd0; f3_tab[7] = 3'd1; f3_tab[8] = 3'd3; f3_tab[9] = 3'd7;
    for (int k = 0; k < 1024; k++) begin
      r = $urandom;
      shadow[k] = r;
      env_mem[k] <= r;
    end
    shadow[64] = 32'h80FF7F01; env_mem[64] <= 32'h80FF7F01;
    shadow[65] = 32'hDEADBEEF; env_mem[65] <= 32'hDEADBEEF;

    // Requests held high through reset must not be granted
    i_valid = 1'b1; i_addr = 32'h200; d_valid = 1'b1; d_addr = 32'h100; d_funct3 = 3'b010;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset readys", 32'({i_ready, d_ready}), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK); #1;
    chk("first grant d", 32'({i_ready, d_ready}), 32'b01);
    @(posedge CLK); #1;
    chk("first d_rvalid", 32'(d_rvalid), 32'd1);
    chk("first d_rdata", d_rdata, 32'h80FF7F01);
    d_valid = 1'b0;
    @(negedge CLK); #1;
    chk("then grant i", 32'(i_ready), 32'd1);
    @(posedge CLK); #1;
    i_valid = 1'b0;

    d_op(1'b0, 3'd0, 32'h101, 32'd0, 4'd0, 32'd0, 32'h0000007F, 1'b0, "LB 101");
    d_op(1'b0, 3'd0, 32'h103, 32'd0, 4'd0, 32'd0, 32'hFFFFFF80, 1'b0, "LB 103");
    d_op(1'b0, 3'd5, 32'h102, 32'd0, 4'd0, 32'd0, 32'h000080FF, 1'b0, "LHU 102");
    d_op(1'b0, 3'd1, 32'h102, 32'd0, 4'd0, 32'd0, 32'hFFFF80FF, 1'b0, "LH 102");
    d_op(1'b1, 3'd0, 32'h102, 32'h000000AB, 4'b0100, 32'hABABABAB, 32'd0, 1'b0, "SB 102");
    d_op(1'b1, 3'd1, 32'h102, 32'h00001234, 4'b1100, 32'h12341234, 32'd0, 1'b0, "SH 102");
    d_op(1'b0, 3'd2, 32'h100, 32'd0, 4'd0, 32'd0, 32'h12347F01, 1'b0, "LW 100");
    d_op(1'b1, 3'd2, 32'h105, 32'h55555555, 4'd0, 32'd0, 32'd0, 1'b1, "SW 105");
    d_op(1'b0, 3'd2, 32'h104, 32'd0, 4'd0, 32'd0, 32'hDEADBEEF, 1'b0, "LW 104");
    d_op(1'b1, 3'd4, 32'h100, 32'h11, 4'd0, 32'd0, 32'd0, 1'b1, "SBU illegal");
    d_op(1'b0, 3'd3, 32'h100, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1, "funct3 011");

    i_valid = 1'b1; i_addr = 32'h202;
    @(negedge CLK); #1;
    chk("fetch 202 ready", 32'(i_ready), 32'd1);
    @(posedge CLK); #1;
    i_valid = 1'b0;
    chk("fetch 202 rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch 202 err", 32'(i_err), 32'd1);

    run_both(10, 8'h00, seq);
    chk("starve seq DDDDIDDDDI", 32'(seq), 32'h1EF);
    run_both(8, 8'h04, seq);
    chk("i drop clears count", 32'(seq), 32'h7F);

    // Reset in the middle of a stream drops the pending response
    run_both(3, 8'h00, seq);
    d_valid = 1'b1; i_valid = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h100;
    @(negedge CLK); #2;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    chk("reset drops d_rvalid", 32'(d_rvalid), 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    run_both(5, 8'h00, seq);
    chk("count restarts", 32'(seq), 32'h0F);

    for (int c = 0; c < 3000; c++) begin
      if (!i_valid || i_taken) begin
        r = $urandom;
        i_valid = (r[1:0] != 2'd0);
        i_addr  = {20'd0, r[13:4] , (r[15:14] == 2'd0) ? r[3:2] : 2'b00};
      end
      if (!d_valid || d_taken) begin
        r = $urandom;
        d_valid  = (r[1:0] != 2'd0);
        d_we     = r[2];
        d_funct3 = f3_tab[r[31:28] % 10];
        d_addr   = {20'd0, r[13:4], (r[15:14] == 2'd0) ? 2'b00 : r[17:16]};
        d_wdata  = $urandom;
      end
      r = $urandom;
      RESET_N = (r[8:0] != 9'd0);
      @(posedge CLK); #1;
    end
    RESET_N = 1'b1; i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
